// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single shared ALU.
// One operation is in flight at a time. The flow is IDLE (grant and latch
// the operands), then EXEC (capture the ALU outputs), then RESP (hold the
// response until it is accepted).
// Compile-time option: define ALU_ARB_RR_EN to select round-robin
// arbitration. When it is undefined, requester 0 has fixed priority and
// there is no last-grant register.
module alu_arbiter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_cntrl,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_cntrl,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,

    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_cntrl,

    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_negative,
    output logic             resp_zero,
    output logic             resp_overflow,
    output logic             resp_carry_out
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [2:0]       alu_cntrl_q;
    logic             grant_id_q;
    logic             resp_valid_q;
    logic             resp_id_q;
    logic [WIDTH-1:0] resp_result_q;
    logic             resp_negative_q;
    logic             resp_zero_q;
    logic             resp_overflow_q;
    logic             resp_carry_out_q;

`ifdef ALU_ARB_RR_EN
    logic             last_grant_q;
`endif

    // Requester selected for this cycle's possible grant.
    logic             grant_id_d;
    logic             grant_any;

    // Arbitration: choose the winner among the requesters that are valid.
    always_comb begin
        grant_any = req0_valid | req1_valid;
`ifdef ALU_ARB_RR_EN
        if (req0_valid && req1_valid) begin
            grant_id_d = ~last_grant_q;
        end else begin
            grant_id_d = ~req0_valid;
        end
`else
        grant_id_d = ~req0_valid;
`endif
    end

    // Ready is high only in IDLE, and only for the winner, so at most one is high.
    always_comb begin
        req0_ready = (state_q == IDLE) && req0_valid && !grant_id_d;
        req1_ready = (state_q == IDLE) && req1_valid &&  grant_id_d;
    end

    // Control FSM and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            alu_a_q          <= '0;
            alu_b_q          <= '0;
            alu_cntrl_q      <= 3'b000;
            grant_id_q       <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_id_q        <= 1'b0;
            resp_result_q    <= '0;
            resp_negative_q  <= 1'b0;
            resp_zero_q      <= 1'b0;
            resp_overflow_q  <= 1'b0;
            resp_carry_out_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_grant_q     <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        // Op codes, including the unused ones, pass through to the ALU unchanged.
                        alu_a_q     <= grant_id_d ? req1_A     : req0_A;
                        alu_b_q     <= grant_id_d ? req1_B     : req0_B;
                        alu_cntrl_q <= grant_id_d ? req1_cntrl : req0_cntrl;
                        grant_id_q  <= grant_id_d;
`ifdef ALU_ARB_RR_EN
                        last_grant_q <= grant_id_d;
`endif
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result_q    <= alu_result;
                    resp_negative_q  <= alu_negative;
                    resp_zero_q      <= alu_zero;
                    resp_overflow_q  <= alu_overflow;
                    resp_carry_out_q <= alu_carry_out;
                    resp_id_q        <= grant_id_q;
                    resp_valid_q     <= 1'b1;
                    state_q          <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_A          = alu_a_q;
    assign alu_B          = alu_b_q;
    assign alu_cntrl      = alu_cntrl_q;
    assign resp_valid     = resp_valid_q;
    assign resp_id        = resp_id_q;
    assign resp_result    = resp_result_q;
    assign resp_negative  = resp_negative_q;
    assign resp_zero      = resp_zero_q;
    assign resp_overflow  = resp_overflow_q;
    assign resp_carry_out = resp_carry_out_q;

endmodule
